regsfile_mp: RTL and testbench
==============================

Name: regsfile_mp

Overview:
Parametrised multi-port integer register file for the NPC core, replacing the single-port regsfile.
- Configurable number of read and write ports.
- Register 0 optionally hardwired to zero.
- Same-cycle write-to-read bypass.
- Per-register scoreboard (busy bits) that the decode stage uses to detect RAW/WAW hazards.
- Sits between decode (read, allocate) and writeback (write, release).

Parameters:
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
DATA_WIDTH, 32, register data width
NR_READ, 2, number of read ports (>=1)
NR_WRITE, 2, number of write ports (>=1)
ZERO_REG, 1, 1: register 0 reads 0, ignores writes, never busy
BYPASS, 1, 1: a same-cycle write is forwarded to matching reads

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
rf_raddr  in  NR_READ*ADDR_WIDTH  read addresses; port k = slice k
rf_rdata  out  NR_READ*DATA_WIDTH  read data, combinational
rf_rvalid  out  NR_READ  operand ready: register not busy, or bypass hit
rf_we  in  NR_WRITE  write enables
rf_waddr  in  NR_WRITE*ADDR_WIDTH  write addresses
rf_wdata  in  NR_WRITE*DATA_WIDTH  write data
sb_alloc  in  1  decode requests ownership of a destination register
sb_alloc_addr  in  ADDR_WIDTH  destination to mark busy
sb_alloc_ok  out  1  allocation accepted this cycle (combinational)
sb_busy  out  2**ADDR_WIDTH  busy vector, for debug and difftest

Behaviour:
- Reset (async, rst=1): all registers = 0 and all busy bits = 0, immediately and independently of clk. While rst=1:
  - writes and allocations are ignored;
  - rf_rdata = stored value or bypass (0 when no write is enabled);
  - sb_busy = 0; sb_alloc_ok = sb_alloc.
- Write: on the clk rising edge, every port j with rf_we[j]=1 writes rf_wdata[j] to rf_waddr[j].
  - If several ports target the same address, the highest-index port wins.
  - With ZERO_REG=1, writes to address 0 are discarded.
- Read: rf_rdata[k] is combinational from rf_raddr[k]. No registered latency.
  - If BYPASS=1 and any enabled write port targets rf_raddr[k] (non-zero when ZERO_REG=1), output that port's wdata; highest index wins.
  - Otherwise output the stored value.
  - Address 0 with ZERO_REG=1 -> data 0, rvalid 1.
- rf_rvalid[k] = !busy[raddr_k] OR (BYPASS=1 AND bypass hit on port k).
- Scoreboard:
  - busy[i] is set at the clock edge when sb_alloc_ok=1 and sb_alloc_addr=i.
  - busy[i] is cleared at the clock edge when any enabled write port targets i.
  - Allocate and write to the same i in the same cycle -> busy[i] ends at 1. The allocation belongs to a new producer; the write releases the old one.
  - sb_alloc_ok = sb_alloc AND (!busy[a] OR a write to a this cycle). If allocation is refused, decode must hold and retry; state is unchanged.
  - With ZERO_REG=1, allocation of address 0 is always ok and never sets busy.
  - A write to a non-busy register is legal: data is updated and busy stays 0.
- Reset mid-operation: pending busy bits are dropped and no stale writeback is honoured. The pipeline is flushed by the same reset.
- Width rules:
  - Addresses are unsigned and index the full depth 2**ADDR_WIDTH; there is no out-of-range case.
  - Data is stored and returned unmodified.
- The synchronous-for-loop reset style of the old regsfile is not carried over. Reset uses a plain async clear.

Decomposition:
- Package npc_rf_pkg holds:
  - default ADDR_WIDTH/DATA_WIDTH;
  - REG_ZERO = 0;
  - a helper function that extracts slice k from a flattened port vector.
- One sub-module, rf_bypass_sel, instantiated NR_READ times:
  - inputs: one read address, the stored value, all write ports;
  - outputs: selected data and hit flag;
  - implements highest-index-wins priority.
- The scoreboard stays in the top module. It is a single busy vector plus next-state logic.

Test Plan:
- Assert rst mid-cycle after writing x5=0xDEADBEEF and allocating x5 -> without a clk edge, x5 reads 0, rvalid=1, sb_busy=0.
- Port0 writes x3=0x11 and port1 writes x3=0x22 in the same cycle, read x3 same cycle and next cycle -> rdata=0x22 both times (bypass, then stored).
- Write x0=0xFFFFFFFF and allocate x0 -> read x0 = 0, rvalid=1, sb_busy[0]=0, sb_alloc_ok=1.
- Allocate x7, then read x7 next cycle -> rvalid=0. Writeback x7=0x1234 -> same-cycle rdata=0x1234, rvalid=1; following cycle busy[7]=0.
- With x9 busy, request allocation of x9 with no write -> sb_alloc_ok=0. Next cycle, write x9 and allocate x9 together -> sb_alloc_ok=1, busy[9] remains 1, stored x9 = new data.
- With BYPASS=0, write x4=0x55 and read x4 in the same cycle -> rdata = old value. Next cycle -> 0x55.

Source files
------------

// File: rtl/npc_rf_pkg.sv
// Shared defaults and helpers for the multi-port integer register file.
package npc_rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int REG_ZERO  = 0;

  // Low bit position of slice k in a vector made of equal w-bit slices.
  function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/rf_bypass_sel.sv
// Per-read-port operand select: stored value or forwarded write data.
module rf_bypass_sel
  import npc_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int DATA_WIDTH = RF_DATA_W,
  parameter int NR_WRITE   = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic [ADDR_WIDTH-1:0]          raddr,
  input  logic [DATA_WIDTH-1:0]          stored,
  input  logic [NR_WRITE-1:0]            we,
  input  logic [NR_WRITE*ADDR_WIDTH-1:0] waddr,
  input  logic [NR_WRITE*DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           hit
);

  logic [ADDR_WIDTH-1:0] waddr_a [NR_WRITE];
  logic [DATA_WIDTH-1:0] wdata_a [NR_WRITE];

  for (genvar j = 0; j < NR_WRITE; j++) begin : g_unpack
    assign waddr_a[j] = waddr[slice_lo(j, ADDR_WIDTH) +: ADDR_WIDTH];
    assign wdata_a[j] = wdata[slice_lo(j, DATA_WIDTH) +: DATA_WIDTH];
  end

  // Ascending scan so the highest-index matching port overrides the rest.
  always_comb begin
    hit   = 1'b0;
    rdata = stored;
    if (BYPASS != 0) begin
      for (int j = 0; j < NR_WRITE; j++) begin
        if (we[j] && (waddr_a[j] == raddr)) begin
          hit   = 1'b1;
          rdata = wdata_a[j];
        end
      end
    end
    if ((ZERO_REG != 0) && (raddr == ADDR_WIDTH'(REG_ZERO))) begin
      hit   = 1'b0;
      rdata = '0;
    end
  end

endmodule

// File: rtl/regsfile_mp.sv
// Multi-port integer register file with same-cycle bypass and a busy-bit
// scoreboard shared by decode (allocate) and writeback (release).
module regsfile_mp
  import npc_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int DATA_WIDTH = RF_DATA_W,
  parameter int NR_READ    = 2,
  parameter int NR_WRITE   = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NR_READ*ADDR_WIDTH-1:0]  rf_raddr,
  output logic [NR_READ*DATA_WIDTH-1:0]  rf_rdata,
  output logic [NR_READ-1:0]             rf_rvalid,
  input  logic [NR_WRITE-1:0]            rf_we,
  input  logic [NR_WRITE*ADDR_WIDTH-1:0] rf_waddr,
  input  logic [NR_WRITE*DATA_WIDTH-1:0] rf_wdata,
  input  logic                           sb_alloc,
  input  logic [ADDR_WIDTH-1:0]          sb_alloc_addr,
  output logic                           sb_alloc_ok,
  output logic [2**ADDR_WIDTH-1:0]       sb_busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_nxt;
  logic [DEPTH-1:0]      wr_hit;
  logic [NR_WRITE-1:0]   we_eff;
  logic [ADDR_WIDTH-1:0] waddr_a [NR_WRITE];
  logic [DATA_WIDTH-1:0] wdata_a [NR_WRITE];
  logic                  alloc_zero;

  // Writes to the hardwired zero register are dropped before they reach
  // storage, bypass or the scoreboard.
  for (genvar j = 0; j < NR_WRITE; j++) begin : g_wport
    assign waddr_a[j] = rf_waddr[slice_lo(j, ADDR_WIDTH) +: ADDR_WIDTH];
    assign wdata_a[j] = rf_wdata[slice_lo(j, DATA_WIDTH) +: DATA_WIDTH];
    assign we_eff[j]  = rf_we[j] &&
                        !((ZERO_REG != 0) && (waddr_a[j] == ADDR_WIDTH'(REG_ZERO)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '{default: '0};
    end else begin
      for (int j = 0; j < NR_WRITE; j++) begin
        if (we_eff[j]) regs[waddr_a[j]] <= wdata_a[j];
      end
    end
  end

  always_comb begin
    wr_hit = '0;
    for (int j = 0; j < NR_WRITE; j++) begin
      if (we_eff[j]) wr_hit[waddr_a[j]] = 1'b1;
    end
  end

  assign alloc_zero  = (ZERO_REG != 0) && (sb_alloc_addr == ADDR_WIDTH'(REG_ZERO));
  assign sb_alloc_ok = sb_alloc &&
                       (!busy[sb_alloc_addr] || wr_hit[sb_alloc_addr] || alloc_zero);

  // Release first, then allocate: a same-cycle alloc belongs to a new producer.
  always_comb begin
    busy_nxt = busy & ~wr_hit;
    if (sb_alloc_ok && !alloc_zero) busy_nxt[sb_alloc_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign sb_busy = busy;

  for (genvar k = 0; k < NR_READ; k++) begin : g_rport
    logic [ADDR_WIDTH-1:0] raddr_k;
    logic [DATA_WIDTH-1:0] data_k;
    logic                  hit_k;

    assign raddr_k = rf_raddr[slice_lo(k, ADDR_WIDTH) +: ADDR_WIDTH];

    rf_bypass_sel #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NR_WRITE   (NR_WRITE),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
    ) u_sel (
      .raddr  (raddr_k),
      .stored (regs[raddr_k]),
      .we     (we_eff),
      .waddr  (rf_waddr),
      .wdata  (rf_wdata),
      .rdata  (data_k),
      .hit    (hit_k)
    );

    assign rf_rdata[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH] = data_k;
    assign rf_rvalid[k] = !busy[raddr_k] || hit_k;
  end

endmodule

// File: tb/tb_regsfile_mp.sv
// Directed bench for regsfile_mp: default instance plus a BYPASS=0 instance.
module tb_regsfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rf_raddr;
  logic [1:0]  rf_we;
  logic [9:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        sb_alloc;
  logic [4:0]  sb_alloc_addr;

  logic [63:0] rf_rdata, rf_rdata_nb;
  logic [1:0]  rf_rvalid, rf_rvalid_nb;
  logic        sb_alloc_ok, sb_alloc_ok_nb;
  logic [31:0] sb_busy, sb_busy_nb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regsfile_mp u_dut (
    .clk(clk), .rst(rst), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_rvalid(rf_rvalid), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .sb_alloc(sb_alloc), .sb_alloc_addr(sb_alloc_addr),
    .sb_alloc_ok(sb_alloc_ok), .sb_busy(sb_busy)
  );

  regsfile_mp #(.BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata_nb),
    .rf_rvalid(rf_rvalid_nb), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .sb_alloc(sb_alloc), .sb_alloc_addr(sb_alloc_addr),
    .sb_alloc_ok(sb_alloc_ok_nb), .sb_busy(sb_busy_nb)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rf_we    = 2'b00;
    rf_waddr = '0;
    rf_wdata = '0;
    sb_alloc = 1'b0;
    sb_alloc_addr = '0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    rf_we[p] = 1'b1;
    rf_waddr[p*5 +: 5]  = a;
    rf_wdata[p*32 +: 32] = d;
  endtask

  task automatic alloc(input logic [4:0] a);
    sb_alloc = 1'b1;
    sb_alloc_addr = a;
  endtask

  initial begin
    rst = 1'b1;
    rf_raddr = '0;
    idle();
    #2;
    check("reset_busy", sb_busy, 0);
    check("reset_rvalid", rf_rvalid, 2'b11);
    check("reset_rdata", rf_rdata, 0);
    tick();
    rst = 1'b0;
    tick();

    // x5 written and allocated, then reset mid-cycle without a clock edge
    rf_raddr = {5'd0, 5'd5};
    wr(0, 5'd5, 32'hDEADBEEF);
    alloc(5'd5);
    #1;
    check("x5_alloc_ok", sb_alloc_ok, 1);
    check("x5_bypass", rf_rdata[31:0], 32'hDEADBEEF);
    tick();
    idle();
    #1;
    check("x5_stored", rf_rdata[31:0], 32'hDEADBEEF);
    check("x5_rvalid_busy", rf_rvalid[0], 0);
    check("x5_busy", sb_busy[5], 1);
    rst = 1'b1;
    #1;
    check("rst_x5_rdata", rf_rdata[31:0], 0);
    check("rst_x5_rvalid", rf_rvalid[0], 1);
    check("rst_busy", sb_busy, 0);
    alloc(5'd5);
    wr(0, 5'd5, 32'h000000AB);
    #1;
    check("rst_alloc_ok", sb_alloc_ok, 1);
    check("rst_bypass", rf_rdata[31:0], 32'hAB);
    idle();
    #1;
    rst = 1'b0;
    tick();
    check("post_rst_x5", rf_rdata[31:0], 0);
    check("post_rst_busy", sb_busy, 0);

    // Two ports write x3 in the same cycle: port 1 wins
    rf_raddr = {5'd0, 5'd3};
    wr(0, 5'd3, 32'h11);
    wr(1, 5'd3, 32'h22);
    #1;
    check("x3_bypass_prio", rf_rdata[31:0], 32'h22);
    check("x3_bypass_rvalid", rf_rvalid[0], 1);
    tick();
    idle();
    #1;
    check("x3_stored_prio", rf_rdata[31:0], 32'h22);

    // Zero register ignores writes and allocations
    rf_raddr = {5'd0, 5'd3};
    wr(0, 5'd0, 32'hFFFFFFFF);
    alloc(5'd0);
    #1;
    check("x0_bypass", rf_rdata[63:32], 0);
    check("x0_rvalid", rf_rvalid[1], 1);
    check("x0_alloc_ok", sb_alloc_ok, 1);
    tick();
    idle();
    #1;
    check("x0_stored", rf_rdata[63:32], 0);
    check("x0_busy", sb_busy[0], 0);

    // Allocate x7, read busy, writeback with same-cycle bypass
    rf_raddr = {5'd0, 5'd7};
    alloc(5'd7);
    #1;
    check("x7_alloc_ok", sb_alloc_ok, 1);
    tick();
    idle();
    #1;
    check("x7_rvalid_busy", rf_rvalid[0], 0);
    check("x7_busy", sb_busy[7], 1);
    wr(1, 5'd7, 32'h1234);
    #1;
    check("x7_wb_bypass", rf_rdata[31:0], 32'h1234);
    check("x7_wb_rvalid", rf_rvalid[0], 1);
    tick();
    idle();
    #1;
    check("x7_released", sb_busy[7], 0);
    check("x7_stored", rf_rdata[31:0], 32'h1234);
    check("x7_rvalid", rf_rvalid[0], 1);

    // x9 busy: refused re-allocation, then write+alloc together
    rf_raddr = {5'd0, 5'd9};
    alloc(5'd9);
    tick();
    #1;
    check("x9_refused", sb_alloc_ok, 0);
    tick();
    check("x9_still_busy", sb_busy[9], 1);
    wr(0, 5'd9, 32'hCAFE);
    #1;
    check("x9_wr_alloc_ok", sb_alloc_ok, 1);
    tick();
    idle();
    #1;
    check("x9_busy_kept", sb_busy[9], 1);
    check("x9_stored", rf_rdata[31:0], 32'hCAFE);
    check("x9_rvalid", rf_rvalid[0], 0);

    // BYPASS=0 instance returns the old value until the edge
    rf_raddr = {5'd4, 5'd0};
    wr(0, 5'd4, 32'h33);
    tick();
    idle();
    wr(0, 5'd4, 32'h55);
    #1;
    check("nb_old_value", rf_rdata_nb[63:32], 32'h33);
    check("byp_new_value", rf_rdata[63:32], 32'h55);
    tick();
    idle();
    #1;
    check("nb_stored", rf_rdata_nb[63:32], 32'h55);
    check("nb_busy", sb_busy_nb[9], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
